laser_sender: RTL and testbench
===============================

// Module: laser_sender
// PURPOSE
//  - AXI-Stream-style byte sink that serialises each accepted byte onto a single on/off laser drive line.
//  - The line uses UART-like framing: start bit, 8 data bits LSB first, stop bit.
//  - It sits between a DMA/stream source and the laser driver pin on the transmit side of the optical link.
//  - One byte is in flight at a time; ready back-pressures the source.
// PARAMETERS
//  CLKS_PER_BIT  4   clock cycles each line bit is held (>=1)
//  GAP_BITS      2   idle bit periods inserted after a frame whose byte had last=1 (>=0)
// PORTS
//  clk    in   1  single system clock, all logic on rising edge
//  rst    in   1  reset, asynchronous, active-low
//  sig    out  1  laser drive; 1 = laser on
//  ready  out  1  stream ready; byte accepted on clk edge with ready&valid
//  data   in   8  stream payload byte
//  keep   in   1  byte-valid qualifier
//  last   in   1  end-of-packet marker
//  valid  in   1  stream valid
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, sig=0, ready=0, counters=0, shift reg=0.
//  - First edge after rst=1: ready=1. All outputs are registered.
//  - IDLE: sig=0, ready=1.
//    - On an edge with ready&valid&keep: latch data and last, ready<=0, sig<=1, go START.
//    - On ready&valid&!keep: byte consumed and discarded, no frame, remain IDLE with ready=1.
//    - A discarded byte's last still triggers GAP: ready<=0, go GAP.
//  - START: sig=1 for CLKS_PER_BIT cycles, then DATA.
//  - DATA: bits data[0]..data[7]; sig = current bit, each held CLKS_PER_BIT cycles.
//  - STOP: sig=0 for CLKS_PER_BIT cycles. Then:
//    - if latched last=1 and GAP_BITS>0: go GAP;
//    - else IDLE, with ready=1 on the same edge sig leaves STOP.
//  - GAP: sig=0, ready=0 for GAP_BITS*CLKS_PER_BIT cycles, then IDLE, ready=1.
//  - Latency: sig rises on the edge that accepts the byte, so it is visible the cycle after the handshake.
//  - Frame length: exactly 10*CLKS_PER_BIT cycles. Min byte period with valid held: 10*CLKS_PER_BIT+1 cycles (one IDLE cycle).
//  - Source handshake:
//    - valid may toggle freely; data/keep/last are sampled only on the accepting edge.
//    - Changes while ready=0 are ignored; a byte is never taken twice.
//  - valid dropping mid-frame does not affect the frame in progress.
//  - rst low mid-frame aborts immediately: sig=0, ready=0, state IDLE; the byte is lost.
//  - Bit counter 3 bits, wraps 7->0 on DATA exit; cycle counter sized clog2(max(CLKS_PER_BIT,GAP_BITS*CLKS_PER_BIT)).
// STRUCTURE
//  - Shared package laser_pkg:
//    - state enum {IDLE, START, DATA, STOP, GAP};
//    - constants FRAME_BITS=10, DATA_BITS=8, idle/start/stop line levels.
//  - One sub-module, laser_bit_timer: cycle counter with load/enable, emits a one-cycle tick at the end of each bit period.
//  - Top holds FSM, shift register, last flag.
// TESTING (CLKS_PER_BIT=4, GAP_BITS=2)
//  - Reset: rst=0 then 1 -> sig=0, ready=0 during reset; ready=1 on first edge after release.
//  - Single byte 0x01, keep=1, last=0:
//    - sig = 1x4 (start), 1x4, 0x28, 0x4 (stop);
//    - ready low exactly 40 cycles, then high.
//  - valid held 1, data incrementing on each handshake:
//    - consecutive frames carry 0x00, 0x01, 0x02...;
//    - handshakes 41 cycles apart, no byte skipped or repeated.
//  - valid toggling every 20 cycles: no capture while ready=0 or valid=0; frame bits unaffected by valid.
//  - Byte 0xA5 with last=1:
//    - bits 1,0,1,0,0,1,0,1 after start;
//    - then 8 extra sig=0 cycles with ready=0 before ready=1.
//  - keep=0 byte: ready stays 1, sig stays 0, next keep=1 byte framed normally.
//  - rst pulsed low mid DATA -> sig=0, ready=0 at once; clean full frame for next byte after release.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and line-level constants for the laser byte serialiser.
package laser_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/laser_bit_timer.sv
// Down-counting period timer: load N-1, tick on the cycle the count reaches zero.
module laser_bit_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          tick
);
    logic [CW-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/laser_sender.sv
// Stream byte sink that frames each kept byte as start/8 data LSB-first/stop on the laser line.
module laser_sender
    import laser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       sig,
    output logic       ready,
    input  logic [7:0] data,
    input  logic       keep,
    input  logic       last,
    input  logic       valid
);
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int MAXC    = imax(CLKS_PER_BIT, GAP_CYC);
    localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam bit HAS_GAP = (GAP_BITS > 0);
    localparam logic [CW-1:0] BIT_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          last_q;
    logic          tick;
    logic          tmr_load;
    logic          tmr_en;
    logic [CW-1:0] tmr_val;

    // The timer is reloaded on every state change so each phase starts a fresh period.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = BIT_LD;
        unique case (state)
            IDLE: if (ready && valid && (keep || (last && HAS_GAP))) begin
                tmr_load = 1'b1;
                tmr_val  = keep ? BIT_LD : GAP_LD;
            end
            START, DATA: if (tick) tmr_load = 1'b1;
            STOP: if (tick && last_q && HAS_GAP) begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            default: ;
        endcase
    end

    assign tmr_en = (state != IDLE);

    laser_bit_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sig    <= LINE_IDLE;
            ready  <= 1'b0;
            shreg  <= '0;
            bitcnt <= '0;
            last_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    sig   <= LINE_IDLE;
                    ready <= 1'b1;
                    if (ready && valid) begin
                        if (keep) begin
                            shreg  <= data;
                            last_q <= last;
                            ready  <= 1'b0;
                            sig    <= LINE_START;
                            state  <= START;
                        end else if (last && HAS_GAP) begin
                            // Dropped byte still closes the packet, so the gap is kept.
                            ready <= 1'b0;
                            state <= GAP;
                        end
                    end
                end
                START: if (tick) begin
                    sig    <= shreg[0];
                    shreg  <= {1'b0, shreg[7:1]};
                    bitcnt <= '0;
                    state  <= DATA;
                end
                DATA: if (tick) begin
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'(DATA_BITS - 1)) begin
                        sig   <= LINE_STOP;
                        state <= STOP;
                    end else begin
                        sig   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
                STOP: if (tick) begin
                    if (last_q && HAS_GAP) begin
                        state <= GAP;
                    end else begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                GAP: if (tick) begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_sender.sv
// Randomised bench for laser_sender against a queue-based line waveform model.
module tb_laser_sender;
    localparam int CPB = 4;
    localparam int GB  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sig, ready;
    logic [7:0] data = 8'h00;
    logic       keep = 1'b0;
    logic       last = 1'b0;
    logic       valid = 1'b0;

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit exp_q[$];
    bit m_sig = 1'b0, m_ready = 1'b0, got_hs = 1'b0;

    laser_sender #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP_BITS_W())) dut (
        .clk(clk), .rst(rst), .sig(sig), .ready(ready),
        .data(data), .keep(keep), .last(last), .valid(valid)
    );

    function automatic int GAP_BITS_W();
        return GB;
    endfunction

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Expected line for one accepted byte: start, data LSB first, stop, optional gap.
    task automatic push_frame(input logic [7:0] d, input bit l);
        for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < CPB; i++) exp_q.push_back(d[b]);
        for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
        if (l) for (int i = 0; i < GB * CPB; i++) exp_q.push_back(1'b0);
    endtask

    // Called just after a falling edge with inputs set; returns after the next falling edge.
    task automatic step();
        got_hs = ready && valid;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            exp_q.delete();
            m_sig = 1'b0;
            m_ready = 1'b0;
        end else begin
            if (m_ready && valid) begin
                if (keep) push_frame(data, last);
                else if (last) for (int i = 0; i < GB * CPB; i++) exp_q.push_back(1'b0);
            end
            if (exp_q.size() > 0) begin
                m_sig = exp_q.pop_front();
                m_ready = 1'b0;
            end else begin
                m_sig = 1'b0;
                m_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("sig", 32'(sig), 32'(m_sig));
        chk("ready", 32'(ready), 32'(m_ready));
    endtask

    task automatic send(input logic [7:0] d, input bit k, input bit l);
        bit done = 1'b0;
        data = d; keep = k; last = l; valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = got_hs;
        end
        chk("hs_timeout", 32'(done), 32'd1);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nb, last_hs;
        // Reset held, then released between edges.
        @(negedge clk);
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(3);

        // Single byte 0x01.
        send(8'h01, 1'b1, 1'b0);
        idle(45);

        // valid held, incrementing payload, handshakes 41 cycles apart.
        data = 8'h00; keep = 1'b1; last = 1'b0; valid = 1'b1;
        nb = 0; last_hs = 0;
        for (int i = 0; i < 6 * 41 && nb < 5; i++) begin
            step();
            if (got_hs) begin
                if (nb > 0) chk("hs_spacing", 32'(cyc - last_hs), 32'd41);
                last_hs = cyc;
                nb++;
                data = 8'(nb);
            end
        end
        chk("hs_count", 32'(nb), 32'd5);
        valid = 1'b0;
        idle(45);

        // valid toggling every 20 cycles, payload changing every cycle.
        keep = 1'b1; last = 1'b0;
        for (int i = 0; i < 240; i++) begin
            valid = ((i / 20) % 2) == 0;
            data = 8'($urandom);
            step();
        end
        valid = 1'b0;
        idle(45);

        // 0xA5 closing a packet, followed by the gap.
        send(8'hA5, 1'b1, 1'b1);
        idle(55);

        // Dropped byte, then a normal frame.
        send(8'h3C, 1'b0, 1'b0);
        chk("drop_ready", 32'(ready), 32'd1);
        send(8'($urandom), 1'b1, 1'b0);
        idle(45);
        // Dropped byte with last still produces the gap.
        send(8'h77, 1'b0, 1'b1);
        idle(12);

        // Fully random traffic.
        for (int i = 0; i < 500; i++) begin
            valid = 1'($urandom);
            keep  = ($urandom % 4) != 0;
            last  = ($urandom % 4) == 0;
            data  = 8'($urandom);
            step();
        end
        valid = 1'b0;
        idle(60);

        // Reset mid DATA aborts at once; next byte is framed cleanly.
        send(8'hFF, 1'b1, 1'b0);
        idle(10);
        rst = 1'b0;
        #1;
        chk("abort_sig", 32'(sig), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        idle(2);
        send(8'h5A, 1'b1, 1'b0);
        idle(45);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
